// File: rtl/pwm_step_sequencer.sv
// -----------------------------------------------------------------------------
// pwm_step_sequencer
//
// Steps a pwm_blk instance through a table of (duty_cycle, clk_div, repeat)
// entries. Each entry is applied for reps+1 PWM periods. Changes are applied
// only on the generator's period boundary, when its counter wraps back to 0.
// At that point the PWM output is high for any duty, so updates are glitch-free.
//
// Ports
//   clk, rst           system clock, asynchronous active-high reset
//   cfg_wr_*           table write port, one entry per cycle, any state
//   num_steps          number of active entries, latched at start (clamped to DEPTH)
//   loop_en            wrap to entry 0 after the last entry (sampled live)
//   start / stop       single-cycle control requests
//   pwm_clk_counter    period counter fed back from pwm_blk
//   duty_cycle/clk_div configuration driven into pwm_blk
//   pwm_rst            holds pwm_blk in reset while idle
//   busy               high while running or draining a stop
//   step_idx           index of the entry currently applied
//   done               one-cycle pulse when a sequence ends or a stop completes
// -----------------------------------------------------------------------------
module pwm_step_sequencer #(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3,
   parameter int REP_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_wr_en,
   input  logic [ADDR_W-1:0] cfg_wr_addr,
   input  logic [31:0]       cfg_wr_duty,
   input  logic [4:0]        cfg_wr_div,
   input  logic [REP_W-1:0]  cfg_wr_reps,
   input  logic [ADDR_W:0]   num_steps,
   input  logic              loop_en,
   input  logic              start,
   input  logic              stop,
   input  logic [31:0]       pwm_clk_counter,
   output logic [31:0]       duty_cycle,
   output logic [31:0]       clk_div,
   output logic              pwm_rst,
   output logic              busy,
   output logic [ADDR_W-1:0] step_idx,
   output logic              done
);

   localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_RUN      = 2'd1,
      S_STOPPING = 2'd2
   } state_t;

   // Step table: small, read combinationally so a new entry can be applied
   // on the very edge that closes a period.
   logic [31:0]      duty_mem [DEPTH];
   logic [4:0]       div_mem  [DEPTH];
   logic [REP_W-1:0] reps_mem [DEPTH];

   state_t            state_q, state_d;
   logic [31:0]       duty_q, duty_d;
   logic [4:0]        div_q, div_d;
   logic [ADDR_W-1:0] step_idx_q, step_idx_d;
   logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
   logic [ADDR_W:0]   eff_n_q, eff_n_d;
   logic              prev_nz_q, prev_nz_d;
   logic              done_q, done_d;

   logic              wrap;
   logic              last_step;
   logic [ADDR_W:0]   step_plus1;
   logic              load_en;
   logic [ADDR_W-1:0] load_idx;

   // Table write port; addresses beyond the table are dropped.
   always_ff @(posedge clk) begin
      if (cfg_wr_en && ({1'b0, cfg_wr_addr} < DEPTH_L)) begin
         duty_mem[cfg_wr_addr] <= cfg_wr_duty;
         div_mem[cfg_wr_addr]  <= cfg_wr_div;
         reps_mem[cfg_wr_addr] <= cfg_wr_reps;
      end
   end

   // A wrap is the first cycle the counter reads 0 after a non-zero value.
   // On entry to RUN the counter was held at 0, so prev_nz is 0 and the
   // first cycle of a sequence can never look like a wrap.
   assign wrap       = (pwm_clk_counter == 32'd0) && prev_nz_q;
   assign prev_nz_d  = (pwm_clk_counter != 32'd0);
   assign step_plus1 = {1'b0, step_idx_q} + {{ADDR_W{1'b0}}, 1'b1};
   assign last_step  = (step_plus1 >= eff_n_q);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         duty_q     <= '0;
         div_q      <= '0;
         step_idx_q <= '0;
         rep_cnt_q  <= '0;
         eff_n_q    <= '0;
         prev_nz_q  <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         duty_q     <= duty_d;
         div_q      <= div_d;
         step_idx_q <= step_idx_d;
         rep_cnt_q  <= rep_cnt_d;
         eff_n_q    <= eff_n_d;
         prev_nz_q  <= prev_nz_d;
         done_q     <= done_d;
      end
   end

   // Next-state and step datapath
   always_comb begin
      state_d    = state_q;
      duty_d     = duty_q;
      div_d      = div_q;
      step_idx_d = step_idx_q;
      rep_cnt_d  = rep_cnt_q;
      eff_n_d    = eff_n_q;
      done_d     = 1'b0;
      load_en    = 1'b0;
      load_idx   = '0;

      case (state_q)
         S_IDLE: begin
            // stop beats start; an empty sequence is not started at all
            if (start && !stop && (num_steps != '0)) begin
               state_d  = S_RUN;
               eff_n_d  = (num_steps > DEPTH_L) ? DEPTH_L : num_steps;
               load_en  = 1'b1;
               load_idx = '0;
            end
         end
         S_RUN: begin
            if (wrap) begin
               if (stop) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else if (rep_cnt_q < reps_mem[step_idx_q]) begin
                  rep_cnt_d = rep_cnt_q + 1'b1;
               end else if (!last_step) begin
                  load_en  = 1'b1;
                  load_idx = step_plus1[ADDR_W-1:0];
               end else if (loop_en) begin
                  load_en  = 1'b1;
                  load_idx = '0;
               end else begin
                  // outputs keep their last values; pwm_blk goes back to reset
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end else if (stop) begin
               state_d = S_STOPPING;
            end
         end
         S_STOPPING: begin
            // let the current period finish before releasing the generator
            if (wrap) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (load_en) begin
         duty_d     = duty_mem[load_idx];
         div_d      = div_mem[load_idx];
         step_idx_d = load_idx;
         rep_cnt_d  = '0;
      end
   end

   // Outputs
   always_comb begin
      pwm_rst = (state_q == S_IDLE);
      busy    = (state_q != S_IDLE);
   end

   assign duty_cycle = duty_q;
   assign clk_div    = {27'd0, div_q};
   assign step_idx   = step_idx_q;
   assign done       = done_q;

endmodule

// File: doc/pwm_step_sequencer.md
Name: pwm_step_sequencer

Overview:
Sequences a PWM generator through a programmable table of (duty_cycle, clk_div, repeat) steps. The block sits between the host register interface and a pwm_blk instance. It drives the generator's duty_cycle and clk_div and holds it in reset while idle. It watches the generator's pwm_clk_counter so that configuration changes land only on period boundaries, which gives glitch-free step changes, looping, and graceful stop.

Parameters:
DEPTH, 8, number of step table entries
ADDR_W, 3, table address width; DEPTH <= 2**ADDR_W
REP_W, 8, width of per-step repeat field

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
cfg_wr_en  input  1  table write strobe, one entry per cycle
cfg_wr_addr  input  ADDR_W  table entry index
cfg_wr_duty  input  32  duty_cycle value for the entry
cfg_wr_div  input  5  clk_div value for the entry
cfg_wr_reps  input  REP_W  entry lasts reps+1 PWM periods
num_steps  input  ADDR_W+1  active entries 0..num_steps-1; sampled at start
loop_en  input  1  wrap from the last step back to step 0 instead of finishing
start  input  1  single-cycle start request
stop  input  1  single-cycle stop request
pwm_clk_counter  input  32  counter from pwm_blk
duty_cycle  output  32  to pwm_blk
clk_div  output  32  to pwm_blk; upper 27 bits always 0
pwm_rst  output  1  to pwm_blk rst
busy  output  1  high in RUN or STOPPING
step_idx  output  ADDR_W  index of the step currently applied
done  output  1  one-cycle pulse when the sequence ends or a stop completes

Behaviour:
- Reset values:
  - state = IDLE, pwm_rst = 1, busy = 0, done = 0.
  - duty_cycle = 0, clk_div = 0, step_idx = 0.
  - Internal rep_cnt = 0, prev_nz = 0.
  - The table is not reset; contents are undefined until written.
- Table writes:
  - Accepted in any state. The entry is updated on the clk edge where cfg_wr_en = 1.
  - cfg_wr_addr >= DEPTH is ignored.
  - Outputs are registered at step load. A write to the active entry takes effect the next time that entry is loaded.
- Period wrap detect:
  - prev_nz <= (pwm_clk_counter != 0) every cycle.
  - wrap = (pwm_clk_counter == 0) && prev_nz.
  - At counter 0 the generator outputs 1 for any duty, so updating outputs on the wrap edge is glitch-free.
- Effective step count: eff_n = min(num_steps, DEPTH), latched at start.
- FSM:
  - IDLE:
    - pwm_rst = 1.
    - start = 1, stop = 0, num_steps != 0 → next edge: RUN; load entry 0 into duty_cycle/clk_div; step_idx = 0; rep_cnt = 0; pwm_rst = 0.
    - start with num_steps = 0 is ignored (no done).
    - start together with stop: stop wins, stay IDLE.
  - RUN:
    - start is ignored.
    - On wrap with rep_cnt < reps[step_idx] → rep_cnt++.
    - On wrap with rep_cnt == reps[step_idx]:
      - If step_idx < eff_n-1 → step_idx++, load that entry, rep_cnt = 0.
      - Else if loop_en → step_idx = 0, load entry 0, rep_cnt = 0.
      - Else → IDLE, pwm_rst = 1, done = 1 for one cycle; duty_cycle/clk_div hold their last values.
    - loop_en is sampled live at each last-step wrap.
    - stop without wrap → STOPPING.
    - stop in the same cycle as wrap → IDLE directly with done, no further load.
  - STOPPING:
    - Outputs are held, no step advance.
    - On wrap → IDLE, pwm_rst = 1, done pulse.
    - Further start/stop are ignored.
- Entry to RUN: the counter is 0 and prev_nz is 0, so the first cycle cannot produce a false wrap. The first wrap happens after one full period.
- Latency:
  - start → outputs valid: 1 cycle.
  - wrap → new config at outputs: registered on the same edge, valid the cycle the counter shows 1.
- Async rst mid-sequence: immediate return to reset values; table contents are retained.

Test Plan:
- Bench model of the counter: rst holds it at 0; otherwise it counts 0..P-1 and wraps, with P = 4.
- Scenario 1, single pass: write entry 0 = (duty 1, div 3, reps 0) and entry 1 = (2, 4, 1); num_steps = 2, loop_en = 0, start.
  - Required: 1 cycle later pwm_rst = 0, duty = 1, div = 3.
  - After 4 cycles (wrap): duty = 2, div = 4, step_idx = 1.
  - After 8 more cycles: done pulse, pwm_rst = 1, busy = 0.
- Scenario 2, loop: same table, loop_en = 1.
  - Required: after step 1's second wrap, step_idx = 0 and duty = 1; no done for 40 cycles.
  - Then deassert loop_en: done fires at the end of the next step 1.
- Scenario 3, stop mid-period: stop at counter = 2.
  - Required: busy stays 1 and outputs are unchanged until the counter returns to 0.
  - Then IDLE and done; stop coincident with wrap → IDLE on that edge.
- Scenario 4, boundaries:
  - start with num_steps = 0 → stays IDLE, no done.
  - num_steps = 15 → clamped to 8 (step_idx reaches 7, then done).
  - start+stop together in IDLE → no action.
  - Write to address >= DEPTH → no entry changes.
- Scenario 5, live write: rewrite active entry 1 duty to 9 while step 1 runs with loop_en = 1.
  - Required: current duty stays 2; the next load of step 1 outputs 9.
- Scenario 6, reset mid-RUN: assert rst at step 1.
  - Required: pwm_rst = 1, duty = 0, step_idx = 0 immediately.
  - A subsequent start runs from the retained table.
